// File: rtl/micro_op_sequencer.sv
// micro_op_sequencer: multi-cycle PDP-8 operate-instruction executor, one micro-op event per clock
module micro_op_sequencer #(
   parameter int WORD_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [11:0]           i_reg,
   input  logic [WORD_WIDTH-1:0] ac_in,
   input  logic                  l_in,
   input  logic [WORD_WIDTH-1:0] sr,
   output logic                  busy,
   output logic                  done,
   output logic [WORD_WIDTH-1:0] ac_out,
   output logic                  l_out,
   output logic [WORD_WIDTH-1:0] mq_out,
   output logic                  skip,
   output logic                  halt,
   output logic                  illegal,
   output logic                  micro_g1,
   output logic                  micro_g2,
   output logic                  micro_g3
);
   localparam int W = WORD_WIDTH;
   localparam int H = WORD_WIDTH / 2;

   typedef enum logic [2:0] {IDLE, E1, E2, E3, E4, E4B, DONE} state_t;

   state_t         state, state_nx;
   logic [7:0]     ir;
   logic [W-1:0]   ac, ac_nx, mq, mq_nx, sr_q;
   logic           l, l_nx, sk, sk_nx, hl, hl_nx, il, il_nx;
   logic           bad_op, rar, ral, dbl, skip_c;
   logic [W:0]     lac, lac_inc, rot_v;

   assign bad_op  = i_reg[11:9] != 3'b111;
   assign rar     = ir[3];
   assign ral     = ir[2];
   assign dbl     = (rar ^ ral) & ir[1];
   assign lac     = {l, ac};
   assign lac_inc = lac + (W+1)'(1);
   // one rotate step of {L,AC}; BSW swaps AC halves and leaves L alone; RAR+RAL together rotate nothing
   assign rot_v   = (rar & ~ral) ? {lac[0], lac[W:1]} :
                    (ral & ~rar) ? {lac[W-1:0], lac[W]} :
                    (ir[1] & ~rar & ~ral) ? {lac[W], lac[H-1:0], lac[W-1:H]} : lac;
   assign skip_c  = (ir[6] & ac[W-1]) | (ir[5] & ~|ac) | (ir[4] & l);
   assign busy    = state != IDLE;
   assign done    = state == DONE;
   assign mq_out  = mq;

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   // event sequencing: groups 2/3 stop after E2, group 1 runs through E4 (and E4B for double rotates)
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = bad_op ? DONE : E1;
         E1:      state_nx = E2;
         E2:      state_nx = micro_g1 ? E3 : DONE;
         E3:      state_nx = E4;
         E4:      state_nx = dbl ? E4B : DONE;
         E4B:     state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // per-event next values of the working registers
   always_comb begin
      ac_nx = ac;
      l_nx  = l;
      mq_nx = mq;
      sk_nx = sk;
      hl_nx = hl;
      il_nx = il;
      case (state)
         IDLE: if (start) begin
            ac_nx = ac_in;
            l_nx  = l_in;
            sk_nx = 1'b0;
            hl_nx = 1'b0;
            il_nx = bad_op | (~i_reg[8] & i_reg[3] & i_reg[2]);
         end
         E1: begin
            ac_nx = ir[7] ? '0 : ac;
            if (micro_g1 && ir[6]) l_nx = 1'b0;
            if (micro_g2) sk_nx = skip_c ^ ir[3];
         end
         E2: begin
            if (micro_g1) begin
               if (ir[5]) ac_nx = ~ac;
               if (ir[4]) l_nx = ~l;
            end else if (micro_g2) begin
               if (ir[2]) ac_nx = ac | sr_q;
               if (ir[1]) hl_nx = 1'b1;
            end else if (micro_g3) begin
               if (ir[6] && ir[4]) begin
                  ac_nx = mq;
                  mq_nx = ac;
               end else if (ir[4]) begin
                  mq_nx = ac;
                  ac_nx = '0;
               end else if (ir[6]) ac_nx = ac | mq;
            end
         end
         E3:      if (ir[0]) {l_nx, ac_nx} = lac_inc;
         E4, E4B: {l_nx, ac_nx} = rot_v;
         default: ;
      endcase
   end

   // working registers, operand capture at acceptance, and result publication on entry to DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir       <= '0;
         ac       <= '0;
         l        <= 1'b0;
         mq       <= '0;
         sr_q     <= '0;
         sk       <= 1'b0;
         hl       <= 1'b0;
         il       <= 1'b0;
         ac_out   <= '0;
         l_out    <= 1'b0;
         skip     <= 1'b0;
         halt     <= 1'b0;
         illegal  <= 1'b0;
         micro_g1 <= 1'b0;
         micro_g2 <= 1'b0;
         micro_g3 <= 1'b0;
      end else begin
         ac <= ac_nx;
         l  <= l_nx;
         mq <= mq_nx;
         sk <= sk_nx;
         hl <= hl_nx;
         il <= il_nx;
         if (state == IDLE && start) begin
            ir       <= i_reg[7:0];
            sr_q     <= sr;
            micro_g1 <= ~bad_op & ~i_reg[8];
            micro_g2 <= ~bad_op & i_reg[8] & ~i_reg[0];
            micro_g3 <= ~bad_op & i_reg[8] & i_reg[0];
         end
         if (state != DONE && state_nx == DONE) begin
            ac_out  <= ac_nx;
            l_out   <= l_nx;
            skip    <= sk_nx;
            halt    <= hl_nx;
            illegal <= il_nx;
         end
      end
   end
endmodule

// File: tb/tb_micro_op_sequencer.sv
// tb_micro_op_sequencer: directed tests of the operate-instruction sequencer
module tb_micro_op_sequencer;
   logic        clk = 0, rst_n = 0, start = 0, l_in = 0;
   logic [11:0] i_reg = 0, ac_in = 0, sr = 0;
   logic        busy, done, l_out, skip, halt, illegal, micro_g1, micro_g2, micro_g3;
   logic [11:0] ac_out, mq_out;
   int          total = 0, bad = 0;

   micro_op_sequencer #(.WORD_WIDTH(12)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .i_reg(i_reg), .ac_in(ac_in), .l_in(l_in), .sr(sr),
      .busy(busy), .done(done), .ac_out(ac_out), .l_out(l_out), .mq_out(mq_out), .skip(skip),
      .halt(halt), .illegal(illegal), .micro_g1(micro_g1), .micro_g2(micro_g2), .micro_g3(micro_g3)
   );

   always #5 clk = ~clk;

   // launch one instruction from IDLE and return edges from acceptance to done (-1 on timeout)
   task automatic issue(input logic [11:0] ins, input logic [11:0] a, input logic li,
                        input logic [11:0] s, output int k);
      @(negedge clk);
      for (int n = 0; n < 20 && busy; n++) @(negedge clk);
      i_reg = ins; ac_in = a; l_in = li; sr = s; start = 1;
      @(posedge clk); #1 start = 0;
      k = 0;
      while (!done && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (!done) k = -1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      total++;
      if ({busy, done, l_out, skip, halt, illegal, micro_g1, micro_g2, micro_g3} !== 9'b0) begin
         bad++; $display("FAIL reset_flags: got %b want 000000000",
            {busy, done, l_out, skip, halt, illegal, micro_g1, micro_g2, micro_g3});
      end
      total++;
      if (ac_out !== 12'o0) begin bad++; $display("FAIL reset_ac: got %o want 0", ac_out); end
      total++;
      if (mq_out !== 12'o0) begin bad++; $display("FAIL reset_mq: got %o want 0", mq_out); end
      rst_n = 1;
   endtask

   task automatic test_group1;
      int k;
      issue(12'o7041, 12'o0005, 0, 0, k);
      total++;
      if ({ac_out, l_out} !== {12'o7773, 1'b0}) begin bad++; $display("FAIL cma_iac: got %o l=%b want 7773 l=0", ac_out, l_out); end
      total++;
      if (k !== 4) begin bad++; $display("FAIL cma_iac_k: got %0d want 4", k); end
      total++;
      if ({micro_g1, micro_g2, micro_g3} !== 3'b100) begin bad++; $display("FAIL cma_iac_grp: got %b want 100", {micro_g1, micro_g2, micro_g3}); end
      issue(12'o7041, 12'o0000, 0, 0, k);
      total++;
      if ({ac_out, l_out} !== {12'o0000, 1'b1}) begin bad++; $display("FAIL cma_iac_carry: got %o l=%b want 0000 l=1", ac_out, l_out); end
      issue(12'o7006, 12'o4000, 0, 0, k);
      total++;
      if ({ac_out, l_out} !== {12'o0001, 1'b0}) begin bad++; $display("FAIL rtl: got %o l=%b want 0001 l=0", ac_out, l_out); end
      total++;
      if (k !== 5) begin bad++; $display("FAIL rtl_k: got %0d want 5", k); end
      issue(12'o7002, 12'o0077, 1, 0, k);
      total++;
      if ({ac_out, l_out} !== {12'o7700, 1'b1}) begin bad++; $display("FAIL bsw: got %o l=%b want 7700 l=1", ac_out, l_out); end
      issue(12'o7014, 12'o0001, 0, 0, k);
      total++;
      if ({ac_out, l_out, illegal, k} !== {12'o0001, 1'b0, 1'b1, 32'd4}) begin
         bad++; $display("FAIL rar_ral: got %o l=%b ill=%b k=%0d want 0001 l=0 ill=1 k=4", ac_out, l_out, illegal, k);
      end
   endtask

   task automatic test_group2;
      int k;
      logic [11:0] ins [4] = '{12'o7440, 12'o7450, 12'o7410, 12'o7402};
      logic        exp_sk [4] = '{1, 0, 1, 0};
      logic        exp_hl [4] = '{0, 0, 0, 1};
      for (int i = 0; i < 4; i++) begin
         issue(ins[i], 12'o0000, 0, 0, k);
         total++;
         if ({skip, halt, micro_g2, k} !== {exp_sk[i], exp_hl[i], 1'b1, 32'd2}) begin
            bad++; $display("FAIL grp2_%o: got skip=%b halt=%b g2=%b k=%0d want skip=%b halt=%b g2=1 k=2",
               ins[i], skip, halt, micro_g2, k, exp_sk[i], exp_hl[i]);
         end
      end
      issue(12'o7604, 12'o5555, 0, 12'o1234, k);
      total++;
      if (ac_out !== 12'o1234) begin bad++; $display("FAIL cla_osr: got %o want 1234", ac_out); end
   endtask

   task automatic test_group3;
      int k;
      issue(12'o7421, 12'o1234, 0, 0, k);
      total++;
      if ({mq_out, ac_out, micro_g3, k} !== {12'o1234, 12'o0000, 1'b1, 32'd2}) begin
         bad++; $display("FAIL mql: got mq=%o ac=%o g3=%b k=%0d want mq=1234 ac=0000 g3=1 k=2", mq_out, ac_out, micro_g3, k);
      end
      issue(12'o7501, 12'o0000, 0, 0, k);
      total++;
      if ({ac_out, mq_out} !== {12'o1234, 12'o1234}) begin bad++; $display("FAIL mqa: got ac=%o mq=%o want 1234 1234", ac_out, mq_out); end
   endtask

   task automatic test_illegal;
      int k;
      issue(12'o1234, 12'o4321, 1, 0, k);
      total++;
      if ({ac_out, l_out, illegal, skip, halt, micro_g1, micro_g2, micro_g3, k} !==
          {12'o4321, 1'b1, 1'b1, 5'b0, 32'd0}) begin
         bad++; $display("FAIL illegal: got ac=%o l=%b ill=%b s=%b h=%b g=%b%b%b k=%0d want 4321 1 1 0 0 000 0",
            ac_out, l_out, illegal, skip, halt, micro_g1, micro_g2, micro_g3, k);
      end
   endtask

   task automatic test_busy_ignore;
      int k = 0;
      @(negedge clk);
      for (int n = 0; n < 20 && busy; n++) @(negedge clk);
      i_reg = 12'o7041; ac_in = 12'o0005; l_in = 0; start = 1;
      @(posedge clk); #1 i_reg = 12'o7402; ac_in = 12'o0000;
      @(posedge clk); @(posedge clk); #1 start = 0;
      while (!done && k < 20) begin @(posedge clk); #1; k++; end
      total++;
      if ({ac_out, halt, done} !== {12'o7773, 1'b0, 1'b1}) begin bad++; $display("FAIL busy_ignore: got ac=%o halt=%b done=%b want 7773 0 1", ac_out, halt, done); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL busy_ignore_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_back_to_back;
      int first = -1, second = -1;
      @(negedge clk);
      for (int n = 0; n < 20 && busy; n++) @(negedge clk);
      i_reg = 12'o7402; start = 1;
      for (int c = 0; c < 20 && second < 0; c++) begin
         @(posedge clk); #1;
         if (done) begin
            if (first < 0) first = c;
            else second = c;
         end
      end
      start = 0;
      total++;
      if (second - first !== 4 || first < 0) begin bad++; $display("FAIL back_to_back: got period %0d want 4", second - first); end
   endtask

   task automatic test_reset_mid;
      int pulses = 0;
      @(negedge clk);
      for (int n = 0; n < 20 && busy; n++) @(negedge clk);
      i_reg = 12'o7041; ac_in = 12'o0005; start = 1;
      @(posedge clk); #1 start = 0;
      @(posedge clk); @(posedge clk); #1 rst_n = 0;
      #1;
      total++;
      if ({busy, done, mq_out, ac_out} !== 26'b0) begin
         bad++; $display("FAIL reset_mid: got busy=%b done=%b mq=%o ac=%o want 0 0 0 0", busy, done, mq_out, ac_out);
      end
      @(negedge clk) rst_n = 1;
      for (int c = 0; c < 10; c++) begin @(posedge clk); #1; if (done) pulses++; end
      total++;
      if (pulses !== 0) begin bad++; $display("FAIL reset_mid_done: got %0d pulses want 0", pulses); end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_group1;
      test_group2;
      test_group3;
      test_illegal;
      test_busy_ignore;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
